// File: rtl/replica_exchange_ctrl.sv
// replica_exchange_ctrl
//   Decision side of replica exchange. On start, snapshots every replica's
//   total distance. It then tests adjacent pairs serially, one pair per cycle,
//   with a single shared comparator. The pair phase alternates between
//   even pairs (0-1, 2-3, ...) and odd pairs (1-2, 3-4, ...) on successive runs.
//   A pair (lo, hi) is accepted when
//   (snap[lo] - snap[hi]) * DBETA + rnd >= 0.
//   For each accepted pair, slot lo gets FOLW and slot hi gets PREV. All
//   other slots are NOP.
//
// Ports
//   clk, reset    : clock, synchronous active-high reset
//   start         : begin a run (only honoured in IDLE)
//   busy          : high while evaluating or issuing
//   done          : one-cycle pulse together with cmd_valid
//   dist_flat     : replica k distance at [k*TOTAL_W +: TOTAL_W]
//   rnd           : random threshold, one consumed per evaluation cycle
//   command_flat  : 2-bit command per replica (NOP=0, FOLW=1, PREV=2)
//   cmd_valid     : command_flat valid for exactly one cycle
//   swap_cnt      : accepted swaps in the last completed run
//   phase         : 0 = even pairs next/current, 1 = odd pairs
module replica_exchange_ctrl #(
    parameter int unsigned REPLICA_NUM = 32,
    parameter int unsigned TOTAL_W     = 32,
    parameter int unsigned RND_W       = 16,
    parameter int unsigned DBETA       = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    input  logic [REPLICA_NUM*TOTAL_W-1:0]   dist_flat,
    input  logic [RND_W-1:0]                 rnd,
    output logic [REPLICA_NUM*2-1:0]         command_flat,
    output logic                             cmd_valid,
    output logic [$clog2(REPLICA_NUM):0]     swap_cnt,
    output logic                             phase
);

    localparam logic [1:0] CMD_NOP  = 2'd0;
    localparam logic [1:0] CMD_FOLW = 2'd1;
    localparam logic [1:0] CMD_PREV = 2'd2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EVAL  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;

    localparam int unsigned PAIRS_EVEN = REPLICA_NUM / 2;
    localparam int unsigned PAIRS_ODD  = (REPLICA_NUM - 1) / 2;
    localparam int unsigned PW         = $clog2(REPLICA_NUM);
    localparam int unsigned CW         = $clog2(REPLICA_NUM) + 1;
    // Score width: |diff*DBETA| < 2^(TOTAL_W+clog2(DBETA+1)), plus rnd, plus sign.
    localparam int unsigned SW_D       = TOTAL_W + $clog2(DBETA + 1) + 2;
    localparam int unsigned SW         = (SW_D > RND_W + 2) ? SW_D : RND_W + 2;
    localparam logic signed [SW-1:0] ZERO_S = '0;

    logic [1:0]          state_q, state_d;
    logic [TOTAL_W-1:0]  snap_q [REPLICA_NUM];
    logic [TOTAL_W-1:0]  snap_d [REPLICA_NUM];
    logic [PAIRS_EVEN-1:0] acc_q, acc_d;
    logic [PW-1:0]       p_q, p_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       swap_cnt_q, swap_cnt_d;
    logic                phase_q, phase_d;

    int unsigned         lo_idx;
    int unsigned         pair_num;
    logic [TOTAL_W-1:0]  snap_lo, snap_hi;
    logic signed [TOTAL_W:0] diff;
    logic signed [SW-1:0] score;
    logic                acc;

    // Shared comparator for the pair currently addressed by p_q.
    always_comb begin
        lo_idx  = 2 * 32'(p_q) + 32'(phase_q);
        snap_lo = '0;
        snap_hi = '0;
        for (int unsigned k = 0; k < REPLICA_NUM; k++) begin
            if (k == lo_idx)          snap_lo = snap_q[k];
            if (k == lo_idx + 32'd1)  snap_hi = snap_q[k];
        end
        diff  = $signed({1'b0, snap_lo}) - $signed({1'b0, snap_hi});
        score = SW'(diff) * $signed(SW'(DBETA)) + $signed(SW'(rnd));
        acc   = (score >= ZERO_S);
    end

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        acc_d      = acc_q;
        p_d        = p_q;
        cnt_d      = cnt_q;
        swap_cnt_d = swap_cnt_q;
        phase_d    = phase_q;
        pair_num   = phase_q ? PAIRS_ODD : PAIRS_EVEN;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int unsigned k = 0; k < REPLICA_NUM; k++) begin
                        snap_d[k] = dist_flat[k*TOTAL_W +: TOTAL_W];
                    end
                    acc_d = '0;
                    p_d   = '0;
                    cnt_d = '0;
                    if (pair_num == 0) begin
                        swap_cnt_d = '0;
                        state_d    = S_ISSUE;
                    end else begin
                        state_d = S_EVAL;
                    end
                end
            end
            S_EVAL: begin
                for (int unsigned k = 0; k < PAIRS_EVEN; k++) begin
                    if (k == 32'(p_q)) acc_d[k] = acc;
                end
                cnt_d = cnt_q + CW'(acc);
                p_d   = p_q + PW'(1);
                // Publish the count as ISSUE begins so it is visible with cmd_valid.
                if (32'(p_q) + 32'd1 == pair_num) begin
                    swap_cnt_d = cnt_q + CW'(acc);
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                phase_d = ~phase_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Commands are decoded from the accept vector only while in ISSUE.
    always_comb begin
        command_flat = '0;
        if (state_q == S_ISSUE) begin
            if (!phase_q) begin
                for (int unsigned p = 0; p < PAIRS_EVEN; p++) begin
                    if (acc_q[p]) begin
                        command_flat[2*(2*p)     +: 2] = CMD_FOLW;
                        command_flat[2*(2*p + 1) +: 2] = CMD_PREV;
                    end
                end
            end else begin
                for (int unsigned p = 0; p < PAIRS_ODD; p++) begin
                    if (acc_q[p]) begin
                        command_flat[2*(2*p + 1) +: 2] = CMD_FOLW;
                        command_flat[2*(2*p + 2) +: 2] = CMD_PREV;
                    end
                end
            end
        end
    end

    assign busy      = (state_q == S_EVAL) || (state_q == S_ISSUE);
    assign done      = (state_q == S_ISSUE);
    assign cmd_valid = (state_q == S_ISSUE);
    assign swap_cnt  = swap_cnt_q;
    assign phase     = phase_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            p_q        <= '0;
            cnt_q      <= '0;
            swap_cnt_q <= '0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            p_q        <= p_d;
            cnt_q      <= cnt_d;
            swap_cnt_q <= swap_cnt_d;
            phase_q    <= phase_d;
        end
    end

    // Snapshot contents are don't-care after reset.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

endmodule

// File: tb/tb_replica_exchange_ctrl.sv
// Self-checking bench for replica_exchange_ctrl. Three instances cover
// N=4 (directed and random), N=5 with DBETA=3 (unpaired top replica,
// scaled beta step) and N=2 (zero-pair odd phase).
module tb_replica_exchange_ctrl;

    localparam logic [1:0] NOP  = 2'd0;
    localparam logic [1:0] FOLW = 2'd1;
    localparam logic [1:0] PREV = 2'd2;

    logic clk;
    logic reset;

    logic        start4, busy4, done4, cv4, phase4;
    logic [63:0] dist4;
    logic [7:0]  rnd4;
    logic [7:0]  cmd4;
    logic [2:0]  sc4;

    logic        start5, busy5, done5, cv5, phase5;
    logic [39:0] dist5;
    logic [5:0]  rnd5;
    logic [9:0]  cmd5;
    logic [3:0]  sc5;

    logic        start2, busy2, done2, cv2, phase2;
    logic [15:0] dist2;
    logic [7:0]  rnd2;
    logic [3:0]  cmd2;
    logic [1:0]  sc2;

    int n_checks;
    int n_fail;
    int ph4, ph5, ph2;

    replica_exchange_ctrl #(.REPLICA_NUM(4), .TOTAL_W(16), .RND_W(8), .DBETA(1)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .busy(busy4), .done(done4),
        .dist_flat(dist4), .rnd(rnd4), .command_flat(cmd4), .cmd_valid(cv4),
        .swap_cnt(sc4), .phase(phase4));

    replica_exchange_ctrl #(.REPLICA_NUM(5), .TOTAL_W(8), .RND_W(6), .DBETA(3)) dut5 (
        .clk(clk), .reset(reset), .start(start5), .busy(busy5), .done(done5),
        .dist_flat(dist5), .rnd(rnd5), .command_flat(cmd5), .cmd_valid(cv5),
        .swap_cnt(sc5), .phase(phase5));

    replica_exchange_ctrl #(.REPLICA_NUM(2), .TOTAL_W(8), .RND_W(8), .DBETA(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .dist_flat(dist2), .rnd(rnd2), .command_flat(cmd2), .cmd_valid(cv2),
        .swap_cnt(sc2), .phase(phase2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Reference: evaluate each pair of the given phase from the rules directly.
    function automatic void model(input int n, input int dbeta, input int ph,
                                  input longint d[8], input longint r[8],
                                  output logic [9:0] exp_cmd, output int exp_cnt,
                                  output int exp_lat);
        int np;
        np      = (ph != 0) ? (n - 1) / 2 : n / 2;
        exp_cmd = '0;
        exp_cnt = 0;
        exp_lat = np;
        for (int p = 0; p < np; p++) begin
            int lo;
            lo = 2 * p + ph;
            if ((d[lo] - d[lo + 1]) * dbeta + r[p] >= 0) begin
                exp_cmd[2*lo +: 2]     = FOLW;
                exp_cmd[2*lo + 2 +: 2] = PREV;
                exp_cnt++;
            end
        end
    endfunction

    task automatic drive(input int w, input longint d[8], input longint r, input logic st);
        case (w)
            4: begin
                for (int k = 0; k < 4; k++) dist4[k*16 +: 16] = 16'(d[k]);
                rnd4 = 8'(r); start4 = st;
            end
            5: begin
                for (int k = 0; k < 5; k++) dist5[k*8 +: 8] = 8'(d[k]);
                rnd5 = 6'(r); start5 = st;
            end
            default: begin
                for (int k = 0; k < 2; k++) dist2[k*8 +: 8] = 8'(d[k]);
                rnd2 = 8'(r); start2 = st;
            end
        endcase
    endtask

    function automatic logic [9:0] obs_cmd(input int w);
        case (w)
            4:       return {2'b00, cmd4};
            5:       return cmd5;
            default: return {6'd0, cmd2};
        endcase
    endfunction

    function automatic int obs_sc(input int w);
        case (w)
            4:       return int'(sc4);
            5:       return int'(sc5);
            default: return int'(sc2);
        endcase
    endfunction

    // {cmd_valid, done, busy, phase}
    function automatic logic [3:0] obs_flags(input int w);
        case (w)
            4:       return {cv4, done4, busy4, phase4};
            5:       return {cv5, done5, busy5, phase5};
            default: return {cv2, done2, busy2, phase2};
        endcase
    endfunction

    // One run: start in the current (idle) cycle, feed r[p] in EVAL cycle p,
    // wait (bounded) for cmd_valid, then sample one further cycle.
    task automatic run(input int w, input longint d[8], input longint r[8],
                       input bit perturb, input bit pulse,
                       output int lat, output logic [9:0] cmd, output int sc,
                       output int dones, output logic [9:0] post_cmd,
                       output logic [3:0] post_fl);
        longint dd[8];
        logic [3:0] fl;
        drive(w, d, r[0], 1'b1);
        @(posedge clk); #1;
        lat   = 0;
        fl    = obs_flags(w);
        dones = int'(fl[2]);
        while (fl[3] !== 1'b1 && lat < 20) begin
            for (int k = 0; k < 8; k++) dd[k] = perturb ? longint'($urandom_range(0, 255)) : d[k];
            drive(w, dd, r[lat % 8], pulse);
            @(posedge clk); #1;
            lat++;
            fl = obs_flags(w);
            dones += int'(fl[2]);
        end
        cmd = obs_cmd(w);
        sc  = obs_sc(w);
        drive(w, d, 0, 1'b0);
        @(posedge clk); #1;
        post_cmd = obs_cmd(w);
        post_fl  = obs_flags(w);
        dones += int'(post_fl[2]);
    endtask

    task automatic test_reset;
        int ws[3] = '{4, 5, 2};
        longint z[8] = '{default: 0};
        logic [3:0] fl;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) drive(ws[i], z, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fl = obs_flags(ws[i]);
            n_checks += 3;
            if (obs_cmd(ws[i]) !== 10'h000) begin
                n_fail++; $display("FAIL reset_cmd n=%0d: got %h expected 000", ws[i], obs_cmd(ws[i]));
            end
            if (obs_sc(ws[i]) !== 0) begin
                n_fail++; $display("FAIL reset_swap_cnt n=%0d: got %0d expected 0", ws[i], obs_sc(ws[i]));
            end
            if (fl !== 4'b0000) begin
                n_fail++; $display("FAIL reset_flags n=%0d: got %b expected 0000 (cv,done,busy,phase)", ws[i], fl);
            end
        end
        ph4 = 0; ph5 = 0; ph2 = 0;
    endtask

    task automatic test_main_example;
        longint d[8] = '{100, 50, 70, 90, 0, 0, 0, 0};
        longint r[8] = '{default: 0};
        int lat, sc, dones;
        logic [9:0] cmd, pc;
        logic [3:0] pf;
        run(4, d, r, 1'b0, 1'b0, lat, cmd, sc, dones, pc, pf);
        n_checks += 6;
        if (lat !== 2)          begin n_fail++; $display("FAIL ex1_latency: got %0d expected 2", lat); end
        if (cmd !== 10'h009)    begin n_fail++; $display("FAIL ex1_cmd: got %h expected 009", cmd); end
        if (sc !== 1)           begin n_fail++; $display("FAIL ex1_swap_cnt: got %0d expected 1", sc); end
        if (dones !== 1)        begin n_fail++; $display("FAIL ex1_done_pulses: got %0d expected 1", dones); end
        if (pf !== 4'b0001)     begin n_fail++; $display("FAIL ex1_after_flags: got %b expected 0001", pf); end
        if (pc !== 10'h000)     begin n_fail++; $display("FAIL ex1_after_cmd: got %h expected 000", pc); end
        ph4 = 1;
        r = '{default: 10};
        run(4, d, r, 1'b0, 1'b0, lat, cmd, sc, dones, pc, pf);
        n_checks += 4;
        if (lat !== 1)          begin n_fail++; $display("FAIL ex2_latency: got %0d expected 1", lat); end
        if (cmd !== 10'h000)    begin n_fail++; $display("FAIL ex2_cmd: got %h expected 000", cmd); end
        if (sc !== 0)           begin n_fail++; $display("FAIL ex2_swap_cnt: got %0d expected 0", sc); end
        if (pf[0] !== 1'b0)     begin n_fail++; $display("FAIL ex2_phase: got %b expected 0", pf[0]); end
        ph4 = 0;
    endtask

    task automatic test_boundary;
        longint d[8] = '{40, 50, 0, 0, 0, 0, 0, 0};
        longint r[8] = '{10, 0, 0, 0, 0, 0, 0, 0};
        int lat, sc, dones;
        logic [9:0] cmd, pc;
        logic [3:0] pf;
        // -10 + 10 = 0 accepted; pair 2-3: 0 + 0 accepted.
        run(4, d, r, 1'b0, 1'b0, lat, cmd, sc, dones, pc, pf);
        n_checks += 2;
        if (cmd !== 10'h099) begin n_fail++; $display("FAIL bound_zero_cmd: got %h expected 099", cmd); end
        if (sc !== 2)        begin n_fail++; $display("FAIL bound_zero_swap_cnt: got %0d expected 2", sc); end
        // Odd run: pair 1-2 = 50 - 0, accepted.
        r = '{default: 0};
        run(4, d, r, 1'b0, 1'b0, lat, cmd, sc, dones, pc, pf);
        n_checks += 2;
        if (cmd !== 10'h024) begin n_fail++; $display("FAIL bound_odd_cmd: got %h expected 024", cmd); end
        if (sc !== 1)        begin n_fail++; $display("FAIL bound_odd_swap_cnt: got %0d expected 1", sc); end
        // -10 + 9 = -1 rejected; pair 2-3 still accepted.
        r = '{9, 0, 0, 0, 0, 0, 0, 0};
        run(4, d, r, 1'b0, 1'b0, lat, cmd, sc, dones, pc, pf);
        n_checks += 2;
        if (cmd !== 10'h090) begin n_fail++; $display("FAIL bound_minus1_cmd: got %h expected 090", cmd); end
        if (sc !== 1)        begin n_fail++; $display("FAIL bound_minus1_swap_cnt: got %0d expected 1", sc); end
        ph4 = 1;
    endtask

    task automatic test_snapshot;
        longint d[8], r[8];
        int lat, sc, dones, el, ec;
        logic [9:0] cmd, pc, ecmd;
        logic [3:0] pf;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 8; k++) begin
                d[k] = longint'($urandom_range(0, 300));
                r[k] = longint'($urandom_range(0, 255));
            end
            model(4, 1, ph4, d, r, ecmd, ec, el);
            run(4, d, r, 1'b1, 1'b1, lat, cmd, sc, dones, pc, pf);
            n_checks += 4;
            if (lat !== el)   begin n_fail++; $display("FAIL snap_latency[%0d]: got %0d expected %0d", i, lat, el); end
            if (cmd !== ecmd) begin n_fail++; $display("FAIL snap_cmd[%0d]: got %h expected %h", i, cmd, ecmd); end
            if (sc !== ec)    begin n_fail++; $display("FAIL snap_swap_cnt[%0d]: got %0d expected %0d", i, sc, ec); end
            if (dones !== 1)  begin n_fail++; $display("FAIL snap_done_pulses[%0d]: got %0d expected 1", i, dones); end
            ph4 ^= 1;
        end
    endtask

    task automatic test_back_to_back;
        longint d[8], r[8];
        int lat, sc, dones, el, ec;
        logic [9:0] cmd, pc, ecmd;
        logic [3:0] pf;
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 8; k++) begin
                d[k] = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 65535))
                                                   : longint'($urandom_range(0, 300));
                r[k] = longint'($urandom_range(0, 255));
            end
            model(4, 1, ph4, d, r, ecmd, ec, el);
            run(4, d, r, 1'b0, 1'b0, lat, cmd, sc, dones, pc, pf);
            ph4 ^= 1;
            n_checks += 4;
            if (lat !== el)        begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, el); end
            if (cmd !== ecmd)      begin n_fail++; $display("FAIL b2b_cmd[%0d]: got %h expected %h", i, cmd, ecmd); end
            if (sc !== ec)         begin n_fail++; $display("FAIL b2b_swap_cnt[%0d]: got %0d expected %0d", i, sc, ec); end
            if (int'(pf[0]) !== ph4) begin n_fail++; $display("FAIL b2b_phase[%0d]: got %0d expected %0d", i, pf[0], ph4); end
        end
    endtask

    task automatic test_dbeta_odd_count;
        longint d[8], r[8];
        int lat, sc, dones, el, ec;
        logic [9:0] cmd, pc, ecmd;
        logic [3:0] pf;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 8; k++) begin
                d[k] = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 255))
                                                   : longint'($urandom_range(0, 60));
                r[k] = longint'($urandom_range(0, 63));
            end
            model(5, 3, ph5, d, r, ecmd, ec, el);
            run(5, d, r, 1'b0, 1'b0, lat, cmd, sc, dones, pc, pf);
            ph5 ^= 1;
            n_checks += 4;
            if (lat !== el)        begin n_fail++; $display("FAIL n5_latency[%0d]: got %0d expected %0d", i, lat, el); end
            if (cmd !== ecmd)      begin n_fail++; $display("FAIL n5_cmd[%0d]: got %h expected %h", i, cmd, ecmd); end
            if (sc !== ec)         begin n_fail++; $display("FAIL n5_swap_cnt[%0d]: got %0d expected %0d", i, sc, ec); end
            if (int'(pf[0]) !== ph5) begin n_fail++; $display("FAIL n5_phase[%0d]: got %0d expected %0d", i, pf[0], ph5); end
        end
    endtask

    task automatic test_two_replicas;
        longint d[8] = '{5, 3, 0, 0, 0, 0, 0, 0};
        longint r[8] = '{default: 0};
        int lat, sc, dones;
        logic [9:0] cmd, pc;
        logic [3:0] pf;
        run(2, d, r, 1'b0, 1'b0, lat, cmd, sc, dones, pc, pf);
        n_checks += 3;
        if (lat !== 1)       begin n_fail++; $display("FAIL n2_even_latency: got %0d expected 1", lat); end
        if (cmd !== 10'h009) begin n_fail++; $display("FAIL n2_even_cmd: got %h expected 009", cmd); end
        if (sc !== 1)        begin n_fail++; $display("FAIL n2_even_swap_cnt: got %0d expected 1", sc); end
        run(2, d, r, 1'b0, 1'b0, lat, cmd, sc, dones, pc, pf);
        n_checks += 5;
        if (lat !== 0)       begin n_fail++; $display("FAIL n2_odd_latency: got %0d expected 0", lat); end
        if (cmd !== 10'h000) begin n_fail++; $display("FAIL n2_odd_cmd: got %h expected 000", cmd); end
        if (sc !== 0)        begin n_fail++; $display("FAIL n2_odd_swap_cnt: got %0d expected 0", sc); end
        if (dones !== 1)     begin n_fail++; $display("FAIL n2_odd_done_pulses: got %0d expected 1", dones); end
        if (pf !== 4'b0000)  begin n_fail++; $display("FAIL n2_odd_after_flags: got %b expected 0000", pf); end
        d = '{3, 5, 0, 0, 0, 0, 0, 0};
        r = '{1, 0, 0, 0, 0, 0, 0, 0};
        run(2, d, r, 1'b0, 1'b0, lat, cmd, sc, dones, pc, pf);
        n_checks += 2;
        if (cmd !== 10'h000) begin n_fail++; $display("FAIL n2_minus1_cmd: got %h expected 000", cmd); end
        if (sc !== 0)        begin n_fail++; $display("FAIL n2_minus1_swap_cnt: got %0d expected 0", sc); end
        ph2 = 1;
    endtask

    task automatic test_reset_mid;
        longint d[8] = '{10, 20, 30, 40, 0, 0, 0, 0};
        longint r[8] = '{default: 0};
        int lat, sc, dones, cv_seen;
        logic [9:0] cmd, pc;
        logic [3:0] fl;
        if (ph4 == 0) begin
            run(4, d, r, 1'b0, 1'b0, lat, cmd, sc, dones, pc, fl);
            ph4 = 1;
        end
        drive(4, d, 0, 1'b1);
        @(posedge clk); #1;
        drive(4, d, 0, 1'b0);
        fl = obs_flags(4);
        n_checks++;
        if (fl !== 4'b0011) begin n_fail++; $display("FAIL mid_eval_flags: got %b expected 0011", fl); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        fl = obs_flags(4);
        n_checks += 3;
        if (fl !== 4'b0000)       begin n_fail++; $display("FAIL mid_reset_flags: got %b expected 0000", fl); end
        if (obs_sc(4) !== 0)      begin n_fail++; $display("FAIL mid_reset_swap_cnt: got %0d expected 0", obs_sc(4)); end
        if (obs_cmd(4) !== 10'h0) begin n_fail++; $display("FAIL mid_reset_cmd: got %h expected 000", obs_cmd(4)); end
        cv_seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (cv4 !== 1'b0) cv_seen++;
        end
        n_checks++;
        if (cv_seen !== 0) begin n_fail++; $display("FAIL mid_reset_cmd_valid: got %0d pulses expected 0", cv_seen); end
        ph4 = 0; ph5 = 0; ph2 = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_main_example();
        test_boundary();
        test_snapshot();
        test_back_to_back();
        test_dbeta_odd_count();
        test_two_replicas();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
